// File: rtl/sha256_pkg.sv
// Shared SHA-256 widths and the digest serializer state encoding.
// Pure declarations: no latency or flow control of its own.
// Imported by sha256, sha_engine and sha256_digest_out.
package sha256_pkg;

    localparam int DIGEST_W         = 256;
    localparam int WORD_W           = 32;
    localparam int WORDS_PER_DIGEST = 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/digest_fifo.sv
// Synchronous DEPTH x W digest buffer with extra-MSB pointers.
// Latency: a push is visible on dout_o the edge after it is written.
// A push while full is accepted only when a pop happens on the same edge.
module digest_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/sha256_digest_out.sv
// Captures digests on the rising edge of hash_valid and streams them as 8 words, H0 first.
// Latency: 2 cycles from capture to first word when idle; 8 cycles per digest, no bubbles.
// dout/dout_last hold while stalled; digests arriving with the FIFO full are dropped (sticky overflow).
module sha256_digest_out
    import sha256_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGEST_W-1:0] hash_data,
    input  logic                hash_valid,
    output logic [WORD_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                overflow,
    output logic [CNT_W-1:0]    digest_count
);
    ser_state_t          state_q, state_d;
    logic [DIGEST_W-1:0] shreg_q, shreg_d;
    logic [2:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                hv_q;

    logic                capture, hs, last_word, pop;
    logic                fifo_full, fifo_empty;
    logic [DIGEST_W-1:0] fifo_dout;

    assign capture   = hash_valid & ~hv_q;
    assign hs        = (state_q == S_SEND) & dout_ready;
    assign last_word = (idx_q == 3'(WORDS_PER_DIGEST - 1));
    assign pop       = ~fifo_empty & ((state_q == S_IDLE) | (hs & last_word));

    digest_fifo #(
        .DEPTH (DEPTH),
        .W     (DIGEST_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (capture),
        .pop_i   (pop),
        .din_i   (hash_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | (capture & fifo_full & ~pop);
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shreg_d = fifo_dout;
                    idx_d   = 3'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (!last_word) begin
                        shreg_d = {shreg_q[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
                        idx_d   = idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        // Reload on the final handshake keeps back-to-back digests contiguous.
                        if (pop) begin
                            shreg_d = fifo_dout;
                            idx_d   = 3'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            hv_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            hv_q    <= hash_valid;
        end
    end

    assign dout         = shreg_q[DIGEST_W-1 -: WORD_W];
    assign dout_valid   = (state_q == S_SEND);
    assign dout_last    = dout_valid & last_word;
    assign overflow     = ovf_q;
    assign digest_count = cnt_q;

endmodule

// File: tb/tb_sha256_digest_out.sv
// Randomized bench for sha256_digest_out against a queue-based reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_sha256_digest_out;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] hash_data;
    logic         hash_valid;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         overflow;
    logic [15:0]  digest_count;

    int total = 0;
    int bad   = 0;

    sha256_digest_out #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .hash_data    (hash_data),
        .hash_valid   (hash_valid),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .overflow     (overflow),
        .digest_count (digest_count)
    );

    always #5 clk = ~clk;

    // Reference model: buffered digests in a queue plus the digest being sent.
    logic [255:0] m_fifo[$];
    logic [255:0] m_cur;
    bit           m_busy;
    int           m_idx;
    logic [15:0]  m_cnt;
    bit           m_ovf;
    bit           m_prev_hv;
    logic [31:0]  rx[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_cur     = '0;
        m_busy    = 0;
        m_idx     = 0;
        m_cnt     = '0;
        m_ovf     = 0;
        m_prev_hv = 1;
    endtask

    task automatic model_step(input bit hv, input logic [255:0] data, input bit rdy);
        bit           cap, hs, fin, pop;
        logic [255:0] nd;
        cap       = hv && !m_prev_hv;
        m_prev_hv = hv;
        hs        = m_busy && rdy;
        fin       = hs && (m_idx == 7);
        pop       = (m_fifo.size() > 0) && (!m_busy || fin);
        nd        = '0;
        if (pop) nd = m_fifo.pop_front();
        if (cap) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(data);
            else m_ovf = 1;
        end
        if (fin) begin
            m_cnt = m_cnt + 16'd1;
            if (pop) begin m_cur = nd; m_idx = 0; end
            else m_busy = 0;
        end else if (hs) begin
            m_idx++;
        end else if (!m_busy && pop) begin
            m_busy = 1; m_cur = nd; m_idx = 0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, dout_valid, 0);
        chk({tag, "_last"},  dout_last, 0);
        chk({tag, "_dout"},  dout, 0);
        chk({tag, "_ovf"},   overflow, 0);
        chk({tag, "_cnt"},   digest_count, 0);
    endtask

    // Called at a falling edge: drive, advance one rising edge, compare at the next falling edge.
    task automatic cycle(input bit hv, input logic [255:0] data, input bit rdy);
        hash_valid = hv;
        hash_data  = data;
        dout_ready = rdy;
        if (dout_valid && dout_ready) rx.push_back(dout);
        @(posedge clk);
        model_step(hv, data, rdy);
        @(negedge clk);
        chk("valid", dout_valid, m_busy);
        chk("last", dout_last, m_busy && (m_idx == 7));
        if (m_busy) chk("dout", dout, m_cur[255 - 32*m_idx -: 32]);
        chk("ovf", overflow, m_ovf);
        chk("cnt", digest_count, m_cnt);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [255:0] abc;
        logic [255:0] d [4];
        logic [15:0]  c0;
        int           run, maxrun, guard;
        bit           hv;

        abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

        // Reset with hash_valid already high: that level must not be captured.
        rst = 1'b0; hash_valid = 1'b1; hash_data = rand256(); dout_ready = 1'b0;
        model_reset();
        #1;
        chk_reset("rst0");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1, hash_data, 1);
        chk("hv_at_reset_cnt", digest_count, 0);
        cycle(0, '0, 1);

        // Single "abc" digest: first word two edges after capture.
        rx.delete();
        cycle(1, abc, 1);
        chk("lat_edge_k", dout_valid, 0);
        cycle(0, abc, 1);
        chk("lat_edge_k1", dout_valid, 1);
        chk("first_word", dout, 32'hba7816bf);
        for (int i = 0; i < 10; i++) cycle(0, '0, 1);
        chk("abc_nwords", rx.size(), 8);
        for (int i = 0; i < 8 && i < rx.size(); i++) chk("abc_word", rx[i], abc[255 - 32*i -: 32]);
        chk("abc_cnt", digest_count, 1);

        // Backpressure: ready pattern 1,0,0 repeating.
        rx.delete();
        c0 = m_cnt;
        cycle(1, abc, 1);
        for (int i = 0; i < 40; i++) cycle(0, '0, (i % 3) == 0);
        chk("bp_nwords", rx.size(), 8);
        for (int i = 0; i < 8 && i < rx.size(); i++) chk("bp_word", rx[i], abc[255 - 32*i -: 32]);
        chk("bp_cnt", digest_count, c0 + 16'd1);

        // Back-to-back captures three cycles apart: one unbroken 16-word run.
        d[0] = rand256(); d[1] = rand256();
        run = 0; maxrun = 0;
        for (int i = 0; i < 30; i++) begin
            cycle((i == 0) || (i == 3), (i < 3) ? d[0] : d[1], 1);
            run = dout_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("b2b_run", maxrun, 16);
        chk("b2b_cnt", digest_count, c0 + 16'd3);

        // Held valid for 200 cycles: one digest only.
        c0 = m_cnt;
        d[0] = rand256();
        for (int i = 0; i < 200; i++) cycle(1, d[0], $urandom_range(0, 1));
        for (int i = 0; i < 30; i++) cycle(0, '0, 1);
        chk("held_cnt", digest_count, c0 + 16'd1);

        // Overflow with DEPTH=2: three fit, the fourth is dropped.
        rx.delete();
        c0 = m_cnt;
        for (int k = 0; k < 4; k++) begin
            d[k] = rand256();
            cycle(1, d[k], 0);
            cycle(0, d[k], 0);
            if (k == 2) chk("ovf_after3", overflow, 0);
        end
        chk("ovf_after4", overflow, 1);
        for (int i = 0; i < 40; i++) cycle(0, '0, 1);
        chk("ovf_nwords", rx.size(), 24);
        for (int i = 0; i < 24 && i < rx.size(); i++) chk("ovf_word", rx[i], d[i/8][255 - 32*(i%8) -: 32]);
        chk("ovf_cnt", digest_count, c0 + 16'd3);
        chk("ovf_sticky", overflow, 1);

        // Random traffic.
        hv = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) hv = !hv;
            cycle(hv, rand256(), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40; i++) cycle(0, '0, 1);

        // Reset after word 3 is accepted: everything clears asynchronously.
        cycle(1, rand256(), 1);
        guard = 0;
        while (!(m_busy && m_idx == 4) && guard < 20) begin
            cycle(0, '0, 1);
            guard++;
        end
        chk("ms_reached_word4", guard < 20, 1);
        #2;
        rst = 1'b0; hash_valid = 1'b0;
        #1;
        model_reset();
        chk_reset("ms_async");
        @(negedge clk);
        chk_reset("ms_held");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle(0, '0, 1);
        chk("ms_quiet_cnt", digest_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
